// File: rtl/flag_branch_unit_if.sv
// Interface between the EX/ID pipeline stages and the flag/branch unit.
// The master side is the pipeline, and the slave side is the flag_branch_unit.
interface flag_branch_unit_if #(
    parameter int unsigned CNT_W = 16
);
    logic             ex_valid;
    logic             ex_stall;
    logic [2:0]       ex_zvn;
    logic [2:0]       ex_flag_we;
    logic             id_br_valid;
    logic [2:0]       id_br_cond;
    logic             id_stall;
    logic [2:0]       flags;
    logic             br_taken;
    logic             br_stall;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] taken_cnt;

    modport master (
        output ex_valid, ex_stall, ex_zvn, ex_flag_we,
        output id_br_valid, id_br_cond, id_stall,
        input  flags, br_taken, br_stall, branch_cnt, taken_cnt
    );

    modport slave (
        input  ex_valid, ex_stall, ex_zvn, ex_flag_we,
        input  id_br_valid, id_br_cond, id_stall,
        output flags, br_taken, br_stall, branch_cnt, taken_cnt
    );
endinterface

// File: rtl/flag_branch_unit.sv
// Architectural Z/V/N flag register, ID-stage branch resolution with an optional
// EX->ID flag bypass, and saturating branch/taken statistics counters.
module flag_branch_unit #(
    parameter bit          FWD_EN = 1'b1,
    parameter int unsigned CNT_W  = 16
) (
    input logic               clk,
    input logic               rst_n,
    flag_branch_unit_if.slave bus
);

    typedef enum logic [2:0] {
        CC_NE     = 3'b000,
        CC_EQ     = 3'b001,
        CC_GT     = 3'b010,
        CC_LT     = 3'b011,
        CC_GTE    = 3'b100,
        CC_LTE    = 3'b101,
        CC_OV     = 3'b110,
        CC_UNCOND = 3'b111
    } cond_e;

    localparam int unsigned ZI = 2;
    localparam int unsigned VI = 1;
    localparam int unsigned NI = 0;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             ex_commit;
    logic [2:0]       commit_mask;
    logic [2:0]       flags_q, flags_d;
    logic [2:0]       eff_flags;
    logic             cond_met;
    logic             br_stall;
    logic             br_taken;
    logic             resolve;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
    endfunction

    // Per-bit merge: only enabled bits of a committing EX instruction replace the flags.
    always_comb begin
        ex_commit   = bus.ex_valid & ~bus.ex_stall;
        commit_mask = {3{ex_commit}} & bus.ex_flag_we;
        flags_d     = (commit_mask & bus.ex_zvn) | (~commit_mask & flags_q);
    end

    // The bypassed view is exactly the next-state value of the flag register.
    if (FWD_EN) begin : g_bypass
        assign eff_flags = flags_d;
        assign br_stall  = 1'b0;
    end else begin : g_interlock
        assign eff_flags = flags_q;
        assign br_stall  = bus.id_br_valid & bus.ex_valid & (|bus.ex_flag_we);
    end

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves cond_met unassigned (no latch).
        cond_met = 1'b0;
        case (cond_e'(bus.id_br_cond))
            CC_NE:     cond_met = ~eff_flags[ZI];
            CC_EQ:     cond_met =  eff_flags[ZI];
            CC_GT:     cond_met = ~eff_flags[ZI] & ~eff_flags[NI];
            CC_LT:     cond_met =  eff_flags[NI];
            CC_GTE:    cond_met =  eff_flags[ZI] | (~eff_flags[ZI] & ~eff_flags[NI]);
            CC_LTE:    cond_met =  eff_flags[NI] | eff_flags[ZI];
            CC_OV:     cond_met =  eff_flags[VI];
            CC_UNCOND: cond_met =  1'b1;
            default:   cond_met =  1'b0;
        endcase
    end

    always_comb begin
        br_taken     = bus.id_br_valid & ~br_stall & cond_met;
        resolve      = bus.id_br_valid & ~br_stall & ~bus.id_stall;
        branch_cnt_d = resolve ? sat_inc(branch_cnt_q) : branch_cnt_q;
        taken_cnt_d  = (resolve & br_taken) ? sat_inc(taken_cnt_q) : taken_cnt_q;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            flags_q      <= 3'b000;
            branch_cnt_q <= '0;
            taken_cnt_q  <= '0;
        end else begin
            flags_q      <= flags_d;
            branch_cnt_q <= branch_cnt_d;
            taken_cnt_q  <= taken_cnt_d;
        end
    end

    assign bus.flags      = flags_q;
    assign bus.br_taken   = br_taken;
    assign bus.br_stall   = br_stall;
    assign bus.branch_cnt = branch_cnt_q;
    assign bus.taken_cnt  = taken_cnt_q;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Scoreboard bench: a bypass instance and an interlock instance share the same
// stimulus, and each has its own expectation queue drained by a negedge monitor.
`timescale 1ns/1ps
module tb_flag_branch_unit;

    typedef struct {
        string      name;
        logic [2:0] flags;
        logic       taken;
        logic       stall;
        logic [3:0] bcnt;
        logic [3:0] tcnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t q_fwd[$];
    exp_t q_stl[$];
    exp_t e_fwd, e_stl;
    logic [2:0] cur_flags;

    // Bit f of entry c is the taken result for ccc=c with flags {Z,V,N}=f.
    logic [7:0] taken_tbl [8] = '{8'h0F, 8'hF0, 8'h05, 8'hAA, 8'hF5, 8'hFA, 8'hCC, 8'hFF};

    flag_branch_unit_if #(.CNT_W(4)) bus_fwd ();
    flag_branch_unit_if #(.CNT_W(4)) bus_stl ();

    flag_branch_unit #(.FWD_EN(1'b1), .CNT_W(4)) dut_fwd (.clk(clk), .rst_n(rst_n), .bus(bus_fwd));
    flag_branch_unit #(.FWD_EN(1'b0), .CNT_W(4)) dut_stl (.clk(clk), .rst_n(rst_n), .bus(bus_stl));

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic compare(input string tag, input exp_t e, input logic [2:0] fl,
                           input logic tk, input logic st, input logic [3:0] b, input logic [3:0] t);
        check({tag, ".", e.name, ".flags"},      {1'b0, fl}, {1'b0, e.flags});
        check({tag, ".", e.name, ".br_taken"},   {3'b0, tk}, {3'b0, e.taken});
        check({tag, ".", e.name, ".br_stall"},   {3'b0, st}, {3'b0, e.stall});
        check({tag, ".", e.name, ".branch_cnt"}, b, e.bcnt);
        check({tag, ".", e.name, ".taken_cnt"},  t, e.tcnt);
    endtask

    always @(negedge clk) begin
        if (q_fwd.size() != 0) begin
            e_fwd = q_fwd.pop_front();
            compare("fwd", e_fwd, bus_fwd.flags, bus_fwd.br_taken, bus_fwd.br_stall,
                    bus_fwd.branch_cnt, bus_fwd.taken_cnt);
        end
        if (q_stl.size() != 0) begin
            e_stl = q_stl.pop_front();
            compare("stl", e_stl, bus_stl.flags, bus_stl.br_taken, bus_stl.br_stall,
                    bus_stl.branch_cnt, bus_stl.taken_cnt);
        end
    end

    task automatic drive(input logic rn, input logic ev, input logic es,
                         input logic [2:0] zvn, input logic [2:0] we,
                         input logic bv, input logic [2:0] cc, input logic is);
        @(posedge clk);
        #1;
        rst_n               = rn;
        bus_fwd.ex_valid    = ev;  bus_stl.ex_valid    = ev;
        bus_fwd.ex_stall    = es;  bus_stl.ex_stall    = es;
        bus_fwd.ex_zvn      = zvn; bus_stl.ex_zvn      = zvn;
        bus_fwd.ex_flag_we  = we;  bus_stl.ex_flag_we  = we;
        bus_fwd.id_br_valid = bv;  bus_stl.id_br_valid = bv;
        bus_fwd.id_br_cond  = cc;  bus_stl.id_br_cond  = cc;
        bus_fwd.id_stall    = is;  bus_stl.id_stall    = is;
    endtask

    task automatic idle(input logic rn);
        drive(rn, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0);
    endtask

    task automatic exp_fwd(input string nm, input logic [2:0] fl, input logic tk,
                           input logic st, input logic [3:0] b, input logic [3:0] t);
        q_fwd.push_back('{nm, fl, tk, st, b, t});
    endtask

    task automatic exp_stl(input string nm, input logic [2:0] fl, input logic tk,
                           input logic st, input logic [3:0] b, input logic [3:0] t);
        q_stl.push_back('{nm, fl, tk, st, b, t});
    endtask

    task automatic exp_both(input string nm, input logic [2:0] fl, input logic tk,
                            input logic st, input logic [3:0] b, input logic [3:0] t);
        exp_fwd(nm, fl, tk, st, b, t);
        exp_stl(nm, fl, tk, st, b, t);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(1'b0);
        idle(1'b0);

        // Reset overriding a flag write and a counted branch in the same cycle
        drive(1, 1, 0, 3'b111, 3'b111, 0, 3'b000, 0); exp_both("rst_idle", 3'b000, 0, 0, 0, 0);
        drive(1, 0, 0, 3'b000, 3'b000, 1, 3'b111, 0); exp_both("pre_rst_br", 3'b111, 1, 0, 0, 0);
        drive(0, 1, 0, 3'b111, 3'b111, 1, 3'b111, 0);
        exp_fwd("rst_ovr", 3'b111, 1, 0, 1, 1);
        exp_stl("rst_ovr", 3'b111, 0, 1, 1, 1);
        idle(1'b1); exp_both("rst_after", 3'b000, 0, 0, 0, 0);

        // Partial writes, ex_stall and bubble gating
        drive(1, 1, 0, 3'b101, 3'b111, 0, 3'b000, 0); exp_both("pw_load", 3'b000, 0, 0, 0, 0);
        drive(1, 1, 0, 3'b010, 3'b010, 0, 3'b000, 0); exp_both("pw_101", 3'b101, 0, 0, 0, 0);
        drive(1, 1, 0, 3'b000, 3'b000, 0, 3'b000, 0); exp_both("pw_111", 3'b111, 0, 0, 0, 0);
        drive(1, 1, 1, 3'b000, 3'b111, 0, 3'b000, 0); exp_both("pw_we0", 3'b111, 0, 0, 0, 0);
        drive(1, 0, 0, 3'b000, 3'b111, 0, 3'b000, 0); exp_both("pw_exstall", 3'b111, 0, 0, 0, 0);
        drive(1, 1, 0, 3'b110, 3'b001, 0, 3'b000, 0); exp_both("pw_bubble", 3'b111, 0, 0, 0, 0);
        idle(1'b1); exp_both("pw_dontcare", 3'b110, 0, 0, 0, 0);
        cur_flags = 3'b110;

        // Condition sweep; id_stall keeps the counters still
        for (int f = 0; f < 8; f++) begin
            drive(1, 1, 0, 3'(f), 3'b111, 0, 3'b000, 0);
            exp_both("sw_load", cur_flags, 0, 0, 0, 0);
            cur_flags = 3'(f);
            for (int c = 0; c < 8; c++) begin
                drive(1, 0, 0, 3'b000, 3'b000, 1, 3'(c), 1);
                exp_both($sformatf("sw_f%0d_c%0d", f, c), cur_flags, taken_tbl[c][f], 0, 0, 0);
            end
            drive(1, 0, 0, 3'b000, 3'b000, 0, 3'b111, 0);
            exp_both("sw_nobr", cur_flags, 0, 0, 0, 0);
        end

        // Branch held by id_stall counts once; a not-taken branch counts only in branch_cnt
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 0, 3'b000, 3'b000, 1, 3'b111, 1);
            exp_both("hold", 3'b111, 1, 0, 0, 0);
        end
        drive(1, 0, 0, 3'b000, 3'b000, 1, 3'b111, 0); exp_both("hold_drop", 3'b111, 1, 0, 0, 0);
        drive(1, 0, 0, 3'b000, 3'b000, 1, 3'b000, 0); exp_both("nt_br", 3'b111, 0, 0, 1, 1);
        idle(1'b1); exp_both("nt_cnt", 3'b111, 0, 0, 2, 1);

        // Same-cycle flag write and branch: bypass vs interlock
        idle(1'b0);
        drive(1, 1, 0, 3'b100, 3'b100, 1, 3'b001, 0);
        exp_fwd("byp_c0", 3'b000, 1, 0, 0, 0);
        exp_stl("haz_c0", 3'b000, 0, 1, 0, 0);
        drive(1, 0, 0, 3'b000, 3'b000, 1, 3'b001, 0);
        exp_fwd("byp_c1", 3'b100, 1, 0, 1, 1);
        exp_stl("haz_c1", 3'b100, 1, 0, 0, 0);
        drive(1, 1, 1, 3'b000, 3'b100, 1, 3'b001, 0);
        exp_fwd("exst", 3'b100, 1, 0, 2, 2);
        exp_stl("exst", 3'b100, 0, 1, 1, 1);
        idle(1'b1);
        exp_fwd("exst_after", 3'b100, 0, 0, 3, 3);
        exp_stl("exst_after", 3'b100, 0, 0, 1, 1);

        // Counter saturation at 4 bits
        idle(1'b0);
        for (int i = 0; i < 20; i++) begin
            logic [3:0] v;
            v = (i > 15) ? 4'd15 : 4'(i);
            drive(1, 0, 0, 3'b000, 3'b000, 1, 3'b111, 0);
            exp_both($sformatf("sat_%0d", i), 3'b000, 1, 0, v, v);
        end
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 0, 3'b000, 3'b000, 1, 3'b111, 1);
            exp_both("sat_hold", 3'b000, 1, 0, 15, 15);
        end
        idle(1'b1); exp_both("sat_end", 3'b000, 0, 0, 15, 15);
        idle(1'b1);

        repeat (2) @(negedge clk);
        n_checks++;
        if (q_fwd.size() != 0 || q_stl.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d/%0d pending expectations, expected 0/0", q_fwd.size(), q_stl.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
